posit_decode_pipe: RTL and testbench
====================================

Name: posit_decode_pipe

Overview:
- Parametrised, pipelined successor to the fixed 64-bit posit decoder. Handles any width N and exponent size ES.
- Adds a valid/ready streaming interface and zero/NaR classification flags.
- Sits between the posit operand buffer and the arithmetic datapath (adder/multiplier unpack stage).
- Fixed 2-cycle latency; full throughput of one posit per clock when not back-pressured.

Parameters:
- N, 64, posit width in bits (legal 8..64).
- ES, 2, exponent field width in bits (legal 0..4). The exponent output port is max(ES,1) bits wide.
- RW, $clog2(N)+1, regime output width (derived; not to be overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input posit valid.
- in_ready  out  1  decoder can accept the input this cycle.
- in_posit  in  N  raw posit bit pattern.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  sign bit.
- out_regime  out  RW  signed regime value k.
- out_exponent  out  max(ES,1)  unsigned exponent field.
- out_fraction  out  N  fraction bits, MSB-aligned, hidden bit excluded.
- out_is_zero  out  1  input was all zeros.
- out_is_nar  out  1  input was NaR (1 followed by zeros).

Behaviour:
- Reset: all outputs 0; both stage-valid flags cleared. Reset mid-operation discards all in-flight data.
- Decode arithmetic:
  - sign = in_posit[N-1].
  - body = the low N-1 bits, two's-complemented first when sign = 1.
  - Regime:
    - run of m ones terminated by a 0 (or by running out of bits): k = m-1.
    - run of m zeros terminated by a 1: k = -m.
  - Exponent: the next ES bits after the terminator. Bits truncated off the end read as 0.
  - Fraction: the remaining bits, left-aligned into N bits, zero-filled below.
  - ES = 0: out_exponent is always 0.
- Special cases:
  - Zero: all bits 0 → is_zero = 1, sign = 0, regime = 0, exponent = 0, fraction = 0.
  - NaR: sign = 1 with the rest 0 → is_nar = 1, sign = 1, regime = 0, exponent = 0, fraction = 0.
  - is_zero and is_nar are mutually exclusive.
- Stage 1 (S1) registers:
  - sign and is_zero/is_nar flags.
  - conditionally negated body.
  - leading-run length and run polarity, from a priority encoder over N-1 bits.
- Stage 2 (S2) registers: regime, plus the body shifted left by (run length + 1) to produce exponent and fraction.
  - Shift amount saturates: shifting out all bits yields 0.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid = s2_valid.
  - The combinational out_ready→in_ready path is permitted.
- Output stability: while out_valid && !out_ready, every out_* signal holds stable. S1 holds its data if S2 is full and stalled.
- Simultaneous events: an output transfer and a new S1→S2 move in the same cycle keep throughput at 1/clk with no bubble.
- Ordering: results emerge strictly in input order. No drops, no duplicates.
- Invalid handshakes: data on in_posit is ignored when in_valid = 0.

Test Plan:
- N=64, ES=2, single 0x4000_0000_0000_0000 (1.0) → 2 cycles later out_valid = 1, sign = 0, regime = 0, exponent = 0, fraction = 0. Also 0x5000_… → exponent = 2, regime = 0.
- Negative: 0xC000_0000_0000_0000 → sign = 1, regime = 0, exponent = 0, fraction = 0.
- Extremes:
  - maxpos 0x7FFF_FFFF_FFFF_FFFF → regime = 62, exponent = 0, fraction = 0.
  - minpos 0x0000_0000_0000_0001 → regime = -62, exponent = 0, fraction = 0.
- Specials: 0x0 → is_zero = 1; 0x8000_0000_0000_0000 → is_nar = 1, sign = 1; other fields 0 for both.
- Back-pressure: stream 8 random posits with out_ready low for 5 cycles mid-stream.
  - in_ready drops after 2 accepted items.
  - Outputs are held stable and match the reference model in order.
  - Then 1 result per clock with out_ready = 1.
- Reset and small config:
  - Assert rst with both stages full → out_valid = 0 immediately (async); the first post-reset input is decoded correctly.
  - Rerun scenarios 1, 3 and 4 with N=16, ES=1: 0x4000 → k = 0; 0x7FFF → k = 14.

Source files
------------

// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit decoder: splits a width-N, ES-exponent posit into
// sign, regime, exponent and fraction, and flags zero and NaR, over valid/ready.
module posit_decode_pipe #(
    parameter int N  = 64,
    parameter int ES = 2,
    parameter int RW = $clog2(N) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_posit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic [RW-1:0]                 out_regime,
    output logic [((ES > 0) ? ES : 1)-1:0] out_exponent,
    output logic [N-1:0]                  out_fraction,
    output logic                          out_is_zero,
    output logic                          out_is_nar
);

    localparam int EW = (ES > 0) ? ES : 1;
    localparam int LW = $clog2(N);
    localparam int SW = LW + 1;

    // Handshake: a stage may load when it is empty or when the stage after it
    // moves this cycle; a transfer happens on any cycle where valid && ready.
    logic s1_adv;
    logic s2_adv;
    logic s1_valid_q;
    logic s2_valid_q;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;

    logic [N-2:0] body_d;
    logic [LW-1:0] run_d;
    logic         pol_d;
    logic         zero_d;
    logic         nar_d;
    logic         stop;

    always_comb begin
        body_d = in_posit[N-1] ? (~in_posit[N-2:0] + {{(N-2){1'b0}}, 1'b1})
                               : in_posit[N-2:0];
        pol_d  = body_d[N-2];
        zero_d = (in_posit == '0);
        nar_d  = (in_posit == {1'b1, {(N-1){1'b0}}});
        run_d  = '0;
        stop   = 1'b0;
        // Leading-run length: count bits matching the first body bit until a flip.
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (body_d[i] == pol_d)) begin
                run_d = run_d + LW'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    logic         s1_sign_q;
    logic         s1_zero_q;
    logic         s1_nar_q;
    logic         s1_pol_q;
    logic [N-2:0] s1_body_q;
    logic [LW-1:0] s1_run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_pol_q   <= 1'b0;
            s1_body_q  <= '0;
            s1_run_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= in_posit[N-1];
                s1_zero_q <= zero_d;
                s1_nar_q  <= nar_d;
                s1_pol_q  <= pol_d;
                s1_body_q <= body_d;
                s1_run_q  <= run_d;
            end
        end
    end

    logic [SW-1:0] shift_amt;
    logic [N-2:0]  shifted;
    logic [RW-1:0] run_ext;
    logic [RW-1:0] regime_d;
    logic [EW-1:0] exp_raw;
    logic [N-1:0]  frac_d;
    logic          special;

    // Dropping run + terminator; a run reaching the end shifts out every bit.
    assign shift_amt = {1'b0, s1_run_q} + SW'(1);
    assign shifted   = s1_body_q << shift_amt;
    assign run_ext   = RW'(s1_run_q);
    assign regime_d  = s1_pol_q ? (run_ext - RW'(1)) : (-run_ext);
    assign frac_d    = {shifted[N-2-ES:0], {(ES + 1){1'b0}}};
    assign special   = s1_zero_q || s1_nar_q;

    generate
        if (ES > 0) begin : g_exp
            assign exp_raw = shifted[N-2 -: EW];
        end else begin : g_no_exp
            assign exp_raw = '0;
        end
    endgenerate

    logic          out_sign_q;
    logic [RW-1:0] out_regime_q;
    logic [EW-1:0] out_exponent_q;
    logic [N-1:0]  out_fraction_q;
    logic          out_is_zero_q;
    logic          out_is_nar_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q     <= 1'b0;
            out_sign_q     <= 1'b0;
            out_regime_q   <= '0;
            out_exponent_q <= '0;
            out_fraction_q <= '0;
            out_is_zero_q  <= 1'b0;
            out_is_nar_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign_q     <= s1_sign_q;
                out_regime_q   <= special ? '0 : regime_d;
                out_exponent_q <= special ? '0 : exp_raw;
                out_fraction_q <= special ? '0 : frac_d;
                out_is_zero_q  <= s1_zero_q;
                out_is_nar_q   <= s1_nar_q;
            end
        end
    end

    assign out_sign     = out_sign_q;
    assign out_regime   = out_regime_q;
    assign out_exponent = out_exponent_q;
    assign out_fraction = out_fraction_q;
    assign out_is_zero  = out_is_zero_q;
    assign out_is_nar   = out_is_nar_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe: an N=64/ES=2 and an N=16/ES=1 instance, table
// vectors, back-pressure, reset and random streams against a bit-queue model.
module tb_posit_decode_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct packed {
        logic               sign;
        logic               z;
        logic               nar;
        logic signed [31:0] k;
        logic [3:0]         ex;
        logic [63:0]        frac;
    } dec_t;

    typedef struct {
        logic [63:0] posit;
        int          n;
        dec_t        exp;
    } vec_t;

    logic        iv64, ir64, ov64, or64, os64, oz64, on64;
    logic [63:0] ip64, of64;
    logic [6:0]  oreg64;
    logic [1:0]  oe64;
    logic        iv16, ir16, ov16, or16, os16, oz16, on16;
    logic [15:0] ip16, of16;
    logic [4:0]  oreg16;
    logic [0:0]  oe16;

    posit_decode_pipe #(.N(64), .ES(2)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_posit(ip64),
        .out_valid(ov64), .out_ready(or64), .out_sign(os64), .out_regime(oreg64),
        .out_exponent(oe64), .out_fraction(of64), .out_is_zero(oz64), .out_is_nar(on64)
    );

    posit_decode_pipe #(.N(16), .ES(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_posit(ip16),
        .out_valid(ov16), .out_ready(or16), .out_sign(os16), .out_regime(oreg16),
        .out_exponent(oe16), .out_fraction(of16), .out_is_zero(oz16), .out_is_nar(on16)
    );

    int   checks = 0;
    int   errors = 0;
    dec_t exp_q64[$];
    dec_t exp_q16[$];
    int   in_cnt64 = 0;
    int   out_cnt64 = 0;
    logic hold64 = 1'b0;
    logic hold16 = 1'b0;
    dec_t held64, held16;
    logic rnd_done;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: walk the body as a bit queue, consuming regime, terminator, exponent, fraction.
    function automatic dec_t ref_decode(input logic [63:0] raw, input int n, input int es);
        dec_t        r;
        bit          bq[$];
        logic [63:0] p, body, half;
        int          m;
        bit          pol, b;
        r = '0;
        p = (n == 64) ? raw : (raw & ((64'd1 << n) - 1));
        half = 64'd1 << (n - 1);
        if (p == 0) begin
            r.z = 1'b1;
            return r;
        end
        if (p == half) begin
            r.nar = 1'b1;
            r.sign = 1'b1;
            return r;
        end
        r.sign = p[n-1];
        body = p & (half - 1);
        if (r.sign) body = (half - body) & (half - 1);
        for (int i = n - 2; i >= 0; i--) bq.push_back(body[i]);
        pol = bq[0];
        m = 0;
        while (bq.size() > 0 && bq[0] == pol) begin
            m++;
            b = bq.pop_front();
        end
        if (bq.size() > 0) b = bq.pop_front();
        r.k = pol ? m - 1 : -m;
        for (int i = 0; i < es; i++) begin
            b = 1'b0;
            if (bq.size() > 0) b = bq.pop_front();
            r.ex = {r.ex[2:0], b};
        end
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (bq.size() > 0) b = bq.pop_front();
            r.frac = {r.frac[62:0], b};
        end
        return r;
    endfunction

    function automatic dec_t mk(input logic s, input logic z, input logic nar, input int k,
                                input int ex, input logic [63:0] frac);
        dec_t r;
        r.sign = s; r.z = z; r.nar = nar; r.k = k; r.ex = ex[3:0]; r.frac = frac;
        return r;
    endfunction

    function automatic dec_t cur64();
        dec_t r;
        r.sign = os64; r.z = oz64; r.nar = on64; r.k = $signed(oreg64);
        r.ex = {2'b00, oe64}; r.frac = of64;
        return r;
    endfunction

    function automatic dec_t cur16();
        dec_t r;
        r.sign = os16; r.z = oz16; r.nar = on16; r.k = $signed(oreg16);
        r.ex = {3'b000, oe16}; r.frac = {48'b0, of16};
        return r;
    endfunction

    function automatic logic [63:0] rnd_posit(input int n);
        logic [63:0] p;
        int          sel;
        sel = $urandom_range(0, 9);
        p = {$urandom, $urandom};
        case (sel)
            0: p = '0;
            1: p = 64'd1 << (n - 1);
            2: p = (64'd1 << (n - 1)) - 1;
            3: p = p >> (64 - n + $urandom_range(1, n - 2));
            4: p = ~(p >> (64 - n + $urandom_range(1, n - 2)));
            default: ;
        endcase
        if (n < 64) p = p & ((64'd1 << n) - 1);
        return p;
    endfunction

    // Scoreboard/monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            hold64 = 1'b0;
        end else begin
            if (hold64) begin
                chk("hold64_valid", {127'b0, ov64}, 128'd1);
                chk("hold64_data", cur64(), held64);
            end
            if (ov64 && or64) begin
                out_cnt64++;
                if (exp_q64.size() == 0) chk("spurious64", {127'b0, ov64}, 128'd0);
                else chk("out64", cur64(), exp_q64.pop_front());
            end
            if (iv64 && ir64) begin
                in_cnt64++;
                exp_q64.push_back(ref_decode(ip64, 64, 2));
            end
            hold64 = ov64 && !or64;
            held64 = cur64();
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold16 = 1'b0;
        end else begin
            if (hold16) begin
                chk("hold16_valid", {127'b0, ov16}, 128'd1);
                chk("hold16_data", cur16(), held16);
            end
            if (ov16 && or16) begin
                if (exp_q16.size() == 0) chk("spurious16", {127'b0, ov16}, 128'd0);
                else chk("out16", cur16(), exp_q16.pop_front());
            end
            if (iv16 && ir16) exp_q16.push_back(ref_decode({48'b0, ip16}, 16, 1));
            hold16 = ov16 && !or16;
            held16 = cur16();
        end
    end

    task automatic stream64(input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            int w = 0;
            iv64 = 1'b1;
            ip64 = rnd_posit(64);
            @(negedge clk);
            while (!ir64 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) chk("accept_timeout64", 128'd1, 128'd0);
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                iv64 = 1'b0;
                ip64 = {$urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        iv64 = 1'b0;
    endtask

    task automatic stream16(input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            int          w = 0;
            logic [63:0] p;
            p = rnd_posit(16);
            iv16 = 1'b1;
            ip16 = p[15:0];
            @(negedge clk);
            while (!ir16 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) chk("accept_timeout16", 128'd1, 128'd0);
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                iv16 = 1'b0;
                ip16 = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        iv16 = 1'b0;
    endtask

    task automatic send_wait64(input logic [63:0] p, output dec_t got, output int lat);
        int w = 0;
        iv64 = 1'b1;
        ip64 = p;
        @(negedge clk);
        while (!ir64 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        iv64 = 1'b0;
        ip64 = {$urandom, $urandom};
        lat = 1;
        while (!ov64 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = cur64();
    endtask

    task automatic send_wait16(input logic [15:0] p, output dec_t got, output int lat);
        int w = 0;
        iv16 = 1'b1;
        ip16 = p;
        @(negedge clk);
        while (!ir16 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        iv16 = 1'b0;
        ip16 = 16'($urandom);
        lat = 1;
        while (!ov16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = cur16();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_t got;
        int   lat;
        int   c0, w;

        tbl[0]  = '{64'h4000_0000_0000_0000, 64, mk(0, 0, 0, 0, 0, 64'h0)};
        tbl[1]  = '{64'h5000_0000_0000_0000, 64, mk(0, 0, 0, 0, 2, 64'h0)};
        tbl[2]  = '{64'hC000_0000_0000_0000, 64, mk(1, 0, 0, 0, 0, 64'h0)};
        tbl[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64, mk(0, 0, 0, 62, 0, 64'h0)};
        tbl[4]  = '{64'h0000_0000_0000_0001, 64, mk(0, 0, 0, -62, 0, 64'h0)};
        tbl[5]  = '{64'h0000_0000_0000_0000, 64, mk(0, 1, 0, 0, 0, 64'h0)};
        tbl[6]  = '{64'h8000_0000_0000_0000, 64, mk(1, 0, 1, 0, 0, 64'h0)};
        tbl[7]  = '{64'h4C00_0000_0000_0000, 64, mk(0, 0, 0, 0, 1, 64'h8000_0000_0000_0000)};
        tbl[8]  = '{64'h4000, 16, mk(0, 0, 0, 0, 0, 64'h0)};
        tbl[9]  = '{64'h7FFF, 16, mk(0, 0, 0, 14, 0, 64'h0)};
        tbl[10] = '{64'h0001, 16, mk(0, 0, 0, -14, 0, 64'h0)};
        tbl[11] = '{64'h0000, 16, mk(0, 1, 0, 0, 0, 64'h0)};
        tbl[12] = '{64'h8000, 16, mk(1, 0, 1, 0, 0, 64'h0)};
        tbl[13] = '{64'h6C00, 16, mk(0, 0, 0, 1, 1, 64'h8000)};

        rst = 1'b1;
        iv64 = 1'b0; ip64 = '0; or64 = 1'b1;
        iv16 = 1'b0; ip16 = '0; or16 = 1'b1;
        rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid64", {127'b0, ov64}, 128'd0);
        chk("reset_out64", cur64(), '0);
        chk("reset_valid16", {127'b0, ov16}, 128'd0);
        chk("reset_out16", cur16(), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].n == 64) send_wait64(tbl[i].posit, got, lat);
            else                send_wait16(tbl[i].posit[15:0], got, lat);
            chk($sformatf("latency[%0d]", i), 128'(lat), 128'd2);
            chk($sformatf("vector[%0d]", i), got, tbl[i].exp);
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: stall from empty, confirm two accepted, then full rate.
        or64 = 1'b0;
        c0 = in_cnt64;
        fork
            stream64(8, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_accepted", 128'(in_cnt64 - c0), 128'd2);
                chk("bp_in_ready", {127'b0, ir64}, 128'd0);
                c0 = out_cnt64;
                or64 = 1'b1;
                repeat (8) @(negedge clk);
                #1;
                chk("bp_throughput", 128'(out_cnt64 - c0), 128'd8);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        fork
            begin
                fork
                    stream64(40, 1'b1);
                    stream16(40, 1'b1);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    or64 = ($urandom_range(0, 2) != 0);
                    or16 = ($urandom_range(0, 2) != 0);
                end
            end
        join
        or64 = 1'b1;
        or16 = 1'b1;
        w = 0;
        while ((exp_q64.size() != 0 || exp_q16.size() != 0) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain64", 128'(exp_q64.size()), 128'd0);
        chk("drain16", 128'(exp_q16.size()), 128'd0);

        // Reset with both stages full must clear out_valid without a clock edge.
        or64 = 1'b0;
        or16 = 1'b0;
        fork
            stream64(2, 1'b0);
            stream16(2, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;
        chk("full_before_rst64", {127'b0, ov64}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid64", {127'b0, ov64}, 128'd0);
        chk("async_rst_valid16", {127'b0, ov16}, 128'd0);
        chk("async_rst_out64", cur64(), '0);
        exp_q64.delete();
        exp_q16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        or64 = 1'b1;
        or16 = 1'b1;
        @(posedge clk); #1;
        send_wait64(64'h5000_0000_0000_0000, got, lat);
        chk("post_rst64", got, mk(0, 0, 0, 0, 2, 64'h0));
        chk("post_rst_lat64", 128'(lat), 128'd2);
        send_wait16(16'h7FFF, got, lat);
        chk("post_rst16", got, mk(0, 0, 0, 14, 0, 64'h0));
        repeat (4) @(posedge clk);
        #1;
        chk("final_q64", 128'(exp_q64.size()), 128'd0);
        chk("final_q16", 128'(exp_q16.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
